// File: rtl/vga_scanner.sv
// VGA raster scanner: pixel counters, same-cycle lookup coordinates, colour/sync/blank registered one i_pix_en step behind.
// GAME_AREA_CLIP_EN: when defined, rows at or beyond CLIP_ROWS (default 440) are blanked as outside the game field.
module vga_scanner #(
   parameter int H_ACTIVE  = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_ACTIVE  = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33
`ifdef GAME_AREA_CLIP_EN
   ,
   parameter int CLIP_ROWS = 440
`endif
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_pix_en,
   output logic [9:0]  o_x,
   output logic [8:0]  o_y,
   input  logic [23:0] i_rgb,
   output logic [7:0]  o_r,
   output logic [7:0]  o_g,
   output logic [7:0]  o_b,
   output logic        o_hs,
   output logic        o_vs,
   output logic        o_blank_n,
   output logic        o_frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);

`ifdef GAME_AREA_CLIP_EN
   localparam int V_VIS   = (CLIP_ROWS < V_ACTIVE) ? CLIP_ROWS : V_ACTIVE;
`else
   localparam int V_VIS   = V_ACTIVE;
`endif

   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT  = VW'(V_VIS);
   localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

   logic [HW-1:0] h_cnt_q, h_cnt_d;
   logic [VW-1:0] v_cnt_q, v_cnt_d;
   logic [23:0]   rgb_q, rgb_d;
   logic          hs_q, hs_d;
   logic          vs_q, vs_d;
   logic          blank_n_q, blank_n_d;
   logic          frame_start_q, frame_start_d;

   logic          active;
   logic          h_wrap;
   logic          v_wrap;

   always_comb begin
      active        = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
      h_wrap        = (h_cnt_q == H_LAST);
      v_wrap        = (v_cnt_q == V_LAST);

      o_x           = active ? 10'(h_cnt_q) : 10'd0;
      o_y           = active ? 9'(v_cnt_q)  : 9'd0;

      h_cnt_d       = h_cnt_q;
      v_cnt_d       = v_cnt_q;
      rgb_d         = rgb_q;
      hs_d          = hs_q;
      vs_d          = vs_q;
      blank_n_d     = blank_n_q;
      frame_start_d = 1'b0;

      if (i_pix_en) begin
         h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
         if (h_wrap) begin
            v_cnt_d = v_wrap ? '0 : v_cnt_q + 1'b1;
         end
         // Everything below describes the position being left, so it lags the counters by one step.
         rgb_d         = active ? i_rgb : 24'd0;
         blank_n_d     = active;
         hs_d          = !((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END));
         vs_d          = !((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END));
         frame_start_d = h_wrap && v_wrap;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         h_cnt_q       <= '0;
         v_cnt_q       <= '0;
         rgb_q         <= '0;
         hs_q          <= 1'b1;
         vs_q          <= 1'b1;
         blank_n_q     <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         rgb_q         <= rgb_d;
         hs_q          <= hs_d;
         vs_q          <= vs_d;
         blank_n_q     <= blank_n_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign o_r           = rgb_q[23:16];
   assign o_g           = rgb_q[15:8];
   assign o_b           = rgb_q[7:0];
   assign o_hs          = hs_q;
   assign o_vs          = vs_q;
   assign o_blank_n     = blank_n_q;
   assign o_frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_scanner.sv
// Bench for vga_scanner: a shrunken-timing instance (16x10 total, 8x6 visible) plus a default-timing instance for line-level sync.
module tb_vga_scanner;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst    = 1'b1;
   logic pix_en = 1'b0;

   // Small instance: hsync at h=10..12, vsync at v=7..8.
   logic [9:0]  x;
   logic [8:0]  y;
   logic [7:0]  r, g, b;
   logic        hs, vs, bl, fs;
   logic [23:0] rgb_s;
   assign rgb_s = {x[7:0], y[7:0], 8'hA5};
   wire  [46:0] snap = {x, y, r, g, b, hs, vs, bl, fs};

`ifdef GAME_AREA_CLIP_EN
   localparam int VIS = 4;
`else
   localparam int VIS = 6;
`endif

   vga_scanner #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
`ifdef GAME_AREA_CLIP_EN
      , .CLIP_ROWS(4)
`endif
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_pix_en(pix_en),
      .o_x(x), .o_y(y), .i_rgb(rgb_s),
      .o_r(r), .o_g(g), .o_b(b),
      .o_hs(hs), .o_vs(vs), .o_blank_n(bl), .o_frame_start(fs)
   );

   logic [9:0]  dx;
   logic [8:0]  dy;
   logic [7:0]  dr, dg, db;
   logic        dhs, dvs, dbl, dfs;

   vga_scanner dut_d (
      .i_clk(clk), .i_rst(rst), .i_pix_en(pix_en),
      .o_x(dx), .o_y(dy), .i_rgb(24'hFFFFFF),
      .o_r(dr), .o_g(dg), .o_b(db),
      .o_hs(dhs), .o_vs(dvs), .o_blank_n(dbl), .o_frame_start(dfs)
   );

   typedef struct {
      int          n;
      logic        en;
      logic        rs;
      logic [46:0] exp;
   } vec_t;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic step(input logic en, input logic rs);
      pix_en = en;
      rst    = rs;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [46:0] mk(input int ex, input int ey, input int er, input int eg,
                                      input int eb, input bit ehs, input bit evs,
                                      input bit ebl, input bit efs);
      return {10'(ex), 9'(ey), 8'(er), 8'(eg), 8'(eb), ehs, evs, ebl, efs};
   endfunction

   function automatic vec_t v(input int n, input bit en, input bit rs, input logic [46:0] e);
      vec_t t;
      t.n = n; t.en = en; t.rs = rs; t.exp = e;
      return t;
   endfunction

   vec_t        tbl[19];
   logic [46:0] ref_snap[200];

   initial begin
      logic [46:0] prev;
      logic [9:0]  px;
      logic [8:0]  py;
      int errs, vslow, fsc, blc, en_cnt, cyc, mism, hold_err, lows, first, dvslow;
      logic [7:0] first_r;
      logic en;

      tbl[0]  = v(1,  1, 0, mk(1, 0, 0, 0, 'hA5, 1, 1, 1, 0));
      tbl[1]  = v(3,  0, 0, mk(1, 0, 0, 0, 'hA5, 1, 1, 1, 0));
      tbl[2]  = v(7,  1, 0, mk(0, 0, 7, 0, 'hA5, 1, 1, 1, 0));
      tbl[3]  = v(1,  1, 0, mk(0, 0, 0, 0, 0,    1, 1, 0, 0));
      tbl[4]  = v(2,  1, 0, mk(0, 0, 0, 0, 0,    0, 1, 0, 0));
      tbl[5]  = v(2,  1, 0, mk(0, 0, 0, 0, 0,    0, 1, 0, 0));
      tbl[6]  = v(1,  1, 0, mk(0, 0, 0, 0, 0,    1, 1, 0, 0));
      tbl[7]  = v(3,  1, 0, mk(1, 1, 0, 1, 'hA5, 1, 1, 1, 0));
      tbl[8]  = v(2,  0, 0, mk(1, 1, 0, 1, 'hA5, 1, 1, 1, 0));
`ifdef GAME_AREA_CLIP_EN
      tbl[9]  = v(50, 1, 0, mk(0, 0, 0, 0, 0,    1, 1, 0, 0));
`else
      tbl[9]  = v(50, 1, 0, mk(3, 4, 2, 4, 'hA5, 1, 1, 1, 0));
`endif
      tbl[10] = v(46, 1, 0, mk(0, 0, 0, 0, 0,    1, 0, 0, 0));
      tbl[11] = v(26, 1, 0, mk(0, 0, 0, 0, 0,    0, 0, 0, 0));
      tbl[12] = v(6,  1, 0, mk(0, 0, 0, 0, 0,    1, 1, 0, 0));
      tbl[13] = v(14, 1, 0, mk(0, 0, 0, 0, 0,    1, 1, 0, 0));
      tbl[14] = v(1,  1, 0, mk(0, 0, 0, 0, 0,    1, 1, 0, 1));
      tbl[15] = v(1,  0, 0, mk(0, 0, 0, 0, 0,    1, 1, 0, 0));
      tbl[16] = v(1,  1, 0, mk(1, 0, 0, 0, 'hA5, 1, 1, 1, 0));
      tbl[17] = v(1,  1, 1, mk(0, 0, 0, 0, 0,    1, 1, 0, 0));
      tbl[18] = v(1,  1, 0, mk(1, 0, 0, 0, 'hA5, 1, 1, 1, 0));

      // Reset held with the strobe active.
      step(1, 1);
      step(1, 1);
      chk("reset_small", snap, mk(0, 0, 0, 0, 0, 1, 1, 0, 0));
      chk("reset_dflt_sync", {dhs, dvs, dbl, dfs}, 4'b1100);
      chk("reset_dflt_rgb", {dr, dg, db}, 24'd0);

      for (int i = 0; i < 19; i++) begin
         for (int k = 0; k < tbl[i].n; k++) step(tbl[i].en, tbl[i].rs);
         chk($sformatf("vec%0d", i), snap, tbl[i].exp);
      end

      // Mid-frame reset with strobe low, then restart at (0,0).
      for (int k = 0; k < 52; k++) step(1, 0);
      chk("pre_reset_pos", {x, y}, {10'd5, 9'd3});
      step(0, 1);
      chk("midframe_reset", snap, mk(0, 0, 0, 0, 0, 1, 1, 0, 0));
      step(1, 0);
      chk("after_reset_step", snap, mk(1, 0, 0, 0, 'hA5, 1, 1, 1, 0));

      // Continuous reference run: colour tracking, vsync width, frame pulse count, visible pixels.
      step(0, 1);
      errs = 0; vslow = 0; fsc = 0; blc = 0;
      for (int i = 0; i < 200; i++) begin
         px = x; py = y;
         step(1, 0);
         ref_snap[i] = snap;
         if (bl) begin
            if ({r, g, b} !== {px[7:0], py[7:0], 8'hA5}) errs++;
         end else if ({r, g, b} !== 24'd0) begin
            errs++;
         end
         if (!vs) vslow++;
         if (fs) fsc++;
         if (bl && i < 160) blc++;
      end
      chk("rgb_track_errs", errs, 0);
      chk("vs_low_steps", vslow, 32);
      chk("frame_start_count", fsc, 1);
      chk("visible_pixels", blc, VIS * 8);

      // Same sequence with a random strobe.
      step(0, 1);
      en_cnt = 0; cyc = 0; mism = 0; hold_err = 0;
      while (en_cnt < 200 && cyc < 2000) begin
         en   = 1'($urandom_range(0, 1));
         prev = snap;
         step(en, 0);
         cyc++;
         if (en) begin
            if (snap !== ref_snap[en_cnt]) mism++;
            en_cnt++;
         end else if (snap[46:1] !== prev[46:1] || fs !== 1'b0) begin
            hold_err++;
         end
      end
      chk("rand_enabled_steps", en_cnt, 200);
      chk("rand_vs_continuous", mism, 0);
      chk("rand_hold", hold_err, 0);

      // Default timing: one full line of hsync.
      step(0, 1);
      lows = 0; first = 0; dvslow = 0; first_r = 8'h00;
      for (int p = 1; p <= 800; p++) begin
         step(1, 0);
         if (p == 1) first_r = dr;
         if (!dhs) begin
            lows++;
            if (first == 0) first = p;
         end
         if (!dvs) dvslow++;
      end
      chk("dflt_hs_low_steps", lows, 96);
      chk("dflt_hs_first_pulse", first, 657);
      chk("dflt_vs_quiet", dvslow, 0);
      chk("dflt_first_white", first_r, 8'hFF);
      chk("dflt_line_wrap", {dx, dy}, {10'd0, 9'd1});
      step(1, 0);
      chk("dflt_next_col", dx, 10'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vga_scanner.md
VGA_SCANNER -- requirements
Module: vga_scanner

Interface
REQ-001 Parameters (name, default, meaning): H_ACTIVE 640 visible pixels/line; H_FP 16 front porch; H_SYNC 96 hsync width; H_BP 48 back porch; V_ACTIVE 480 visible lines; V_FP 10; V_SYNC 2; V_BP 33.
REQ-002 Clock and reset SHALL be: i_clk input 1, single system clock; i_rst input 1, reset, synchronous and active-high.
REQ-003 i_pix_en input 1 SHALL be the pixel-advance strobe; all counters and pipeline registers SHALL advance only when it is 1.
REQ-004 o_x output 10 SHALL be the requested pixel column, driven to pixel-lookup blocks.
REQ-005 o_y output 9 SHALL be the requested pixel row.
REQ-006 i_rgb input 24 SHALL be the combinational colour answer for (o_x, o_y), packed {R[23:16],G[15:8],B[7:0]}.
REQ-007 o_r, o_g, o_b output 8 each SHALL be the registered pixel colour.
REQ-008 o_hs and o_vs output 1 each SHALL be the active-low horizontal and vertical sync.
REQ-009 o_blank_n output 1 SHALL be high only while registered colour is visible.
REQ-010 o_frame_start output 1 SHALL pulse for one i_pix_en step when h_cnt=0, v_cnt=0.

Function
REQ-011 h_cnt SHALL count 0..H_ACTIVE+H_FP+H_SYNC+H_BP-1 (default 0..799), wrapping to 0 on each i_pix_en step.
REQ-012 v_cnt SHALL increment only on an h_cnt wrap, counting 0..V_ACTIVE+V_FP+V_SYNC+V_BP-1 (default 0..524), then wrap to 0.
REQ-013 active SHALL be h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
REQ-014 o_x/o_y SHALL equal h_cnt/v_cnt, truncated, while active, and SHALL be 0 otherwise; both SHALL be combinational from the counter registers so the lookup sees them in the same cycle.
REQ-015 On each i_pix_en step: o_r/o_g/o_b SHALL capture i_rgb if active, else 0; o_blank_n SHALL capture active; o_hs SHALL capture 0 iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751); o_vs SHALL capture 0 iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491).
REQ-016 All registered outputs SHALL therefore lag the counter position by exactly one i_pix_en step, keeping colour, blank and sync mutually aligned.
REQ-017 With i_pix_en=0 the counters and all outputs SHALL hold, and o_frame_start SHALL be 0.
REQ-018 Simultaneous h and v wrap (h_cnt=799, v_cnt=524) SHALL produce h_cnt=0, v_cnt=0 and o_frame_start=1 on the same step.
REQ-019 i_rgb SHALL be ignored (no capture) outside the active region.

Reset
REQ-020 While i_rst=1 at a clock edge, regardless of i_pix_en: h_cnt=0, v_cnt=0, o_r=o_g=o_b=0, o_hs=1, o_vs=1, o_blank_n=0, o_frame_start=0.
REQ-021 Reset asserted mid-line or mid-frame SHALL abandon the frame; the first i_pix_en step after release SHALL process position (0,0).

Configuration
REQ-022 Macro GAME_AREA_CLIP_EN: when defined, active SHALL additionally require v_cnt<440 (the 2x-scaled 320x220 game field), o_y SHALL be 0 and colour/blank SHALL be black/0 for rows 440..479; when undefined, all 480 rows SHALL be active per REQ-013.

Verification
REQ-023 Reset, then 800 i_pix_en pulses -> o_hs low for exactly 96 steps starting on the 657th pulse; h_cnt back to 0.
REQ-024 Run 420000 steps (one frame) -> o_vs low for exactly 1600 steps (2 lines); exactly one o_frame_start pulse per 420000 steps.
REQ-025 Drive i_rgb = {o_x[7:0], o_y[7:0], 8'hA5} -> at each step, registered o_r/o_g/o_b equal the previous step's o_x, o_y and 8'hA5 while o_blank_n=1, and 0 while o_blank_n=0.
REQ-026 Toggle i_pix_en with a random 50% pattern -> outputs identical to the continuous run when sampled only on enabled steps.
REQ-027 Assert i_rst for one cycle at h_cnt=300, v_cnt=200 -> next cycle outputs at their reset values; the next enabled step gives o_x=0, o_y=0.
REQ-028 GAME_AREA_CLIP_EN defined, i_rgb=24'hFFFFFF -> row 439 visible white, rows 440..479 o_blank_n=0 with RGB 0; undefined -> row 479 white.
